// File: rtl/div_issue_hilo.sv
// Issue/writeback controller that launches the iterative divider, waits out its latency and
// retires {rem,quot} into HI/LO. Define SIGNED_DIV_EN to enable signed divides.
module div_issue_hilo #(
    parameter int WIDTH       = 32,
    parameter int DIV_LATENCY = 33
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_signed,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic               cancel,
    input  logic               mthi,
    input  logic               mtlo,
    input  logic [WIDTH-1:0]   mt_data,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done,
    output logic               div_rst,
    output logic [WIDTH-1:0]   div_a,
    output logic [WIDTH-1:0]   div_b,
    input  logic [2*WIDTH-1:0] div_dout,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FIX    = 2'd3
    } state_t;

    localparam logic [5:0] LAT_CNT = 6'(DIV_LATENCY);

    state_t             r_state;
    state_t             w_next;
    logic [5:0]         r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_div_a;
    logic [WIDTH-1:0]   r_div_b;
    logic [2*WIDTH-1:0] r_dout;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_idle;
    logic               w_xfer;
    logic               w_dz;
    logic               w_launch;
    logic               w_cap;
    logic               w_fix_wr;
    logic               w_mthi;
    logic               w_mtlo;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg_q;
    logic               w_neg_r;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Handshake: a request transfers on a rising edge when req_valid & req_ready are both
    // high; req_ready is high only in IDLE outside reset, and a cancel in the same cycle
    // drops the transfer.
    assign w_idle   = (r_state == S_IDLE);
    assign w_xfer   = w_idle & req_valid & ~cancel;
    assign w_dz     = w_xfer & (req_b == '0);
    assign w_launch = w_xfer & (req_b != '0);
    assign w_cap    = (r_state == S_WAIT) & (r_cnt == LAT_CNT) & ~cancel;
    assign w_fix_wr = (r_state == S_FIX) & ~cancel;
    assign w_mthi   = w_idle & mthi;
    assign w_mtlo   = w_idle & mtlo;

`ifdef SIGNED_DIV_EN
    always_comb begin
        w_mag_a = req_a;
        w_mag_b = req_b;
        w_neg_q = 1'b0;
        w_neg_r = 1'b0;
        if (req_signed) begin
            if (req_a[WIDTH-1]) w_mag_a = '0 - req_a;
            if (req_b[WIDTH-1]) w_mag_b = '0 - req_b;
            w_neg_q = req_a[WIDTH-1] ^ req_b[WIDTH-1];
            w_neg_r = req_a[WIDTH-1];
        end
    end

    always_comb begin
        w_quot = r_dout[WIDTH-1:0];
        w_rem  = r_dout[2*WIDTH-1:WIDTH];
        if (r_neg_q) w_quot = '0 - r_dout[WIDTH-1:0];
        if (r_neg_r) w_rem  = '0 - r_dout[2*WIDTH-1:WIDTH];
    end
`else
    logic w_unused_signed;
    assign w_unused_signed = req_signed;
    assign w_mag_a = req_a;
    assign w_mag_b = req_b;
    assign w_neg_q = 1'b0;
    assign w_neg_r = 1'b0;
    assign w_quot  = r_dout[WIDTH-1:0];
    assign w_rem   = r_dout[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        div_rst   = 1'b1;
        case (r_state)
            S_IDLE:   if (w_launch) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT:   if (w_cap) w_next = S_FIX;
            S_FIX:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (cancel && !w_idle) w_next = S_IDLE;
        if (!reset) begin
            req_ready = w_idle;
            busy      = !w_idle;
            done      = w_dz | w_fix_wr;
            // The divider runs only while WAIT holds its reset low.
            div_rst   = (r_state != S_WAIT) | cancel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div_a <= '0;
            r_div_b <= '0;
            r_dout  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_div_a <= w_mag_a;
                r_div_b <= w_mag_b;
                r_neg_q <= w_neg_q;
                r_neg_r <= w_neg_r;
            end
            if (r_state == S_LAUNCH) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && r_cnt != 6'h3f) begin
                r_cnt <= r_cnt + 6'd1;
            end
            if (w_cap) r_dout <= div_dout;
            // mthi/mtlo take priority over a same-cycle divide-by-zero shortcut.
            if (w_mthi)        r_hi <= mt_data;
            else if (w_dz)     r_hi <= req_a;
            else if (w_fix_wr) r_hi <= w_rem;
            if (w_mtlo)        r_lo <= mt_data;
            else if (w_dz)     r_lo <= '1;
            else if (w_fix_wr) r_lo <= w_quot;
        end
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_div_issue_hilo.sv
// Directed + randomized bench for div_issue_hilo with a behavioural divider and HI/LO model.
// Follows SIGNED_DIV_EN the same way as the design.
module tb_div_issue_hilo;
    localparam int W   = 32;
    localparam int LAT = 33;
`ifdef SIGNED_DIV_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset, req_valid, req_signed, cancel, mthi, mtlo;
    logic [W-1:0]   req_a, req_b, mt_data;
    logic           req_ready, busy, done, div_rst;
    logic [W-1:0]   hi, lo, div_a, div_b;
    logic [2*W-1:0] div_dout;
    logic [1:0]     dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    always #5 clk = ~clk;

    div_issue_hilo #(.WIDTH(W), .DIV_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_signed(req_signed), .req_a(req_a), .req_b(req_b), .cancel(cancel),
        .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_rst(div_rst), .div_a(div_a), .div_b(div_b),
        .div_dout(div_dout), .dbg_state(dbg_state)
    );

    // Behavioural iterative divider: samples operands on its first edge out of reset and
    // shows the result only after the LAT-th such edge; any other time the output is junk.
    int           dcnt = 0;
    int           opnd_bad = 0;
    logic [W-1:0] da = '0;
    logic [W-1:0] db = '0;
    always @(posedge clk) begin
        if (div_rst) begin
            dcnt     <= 0;
            div_dout <= {$urandom, $urandom};
        end else begin
            dcnt <= dcnt + 1;
            if (dcnt == 0) begin
                da <= div_a;
                db <= div_b;
            end else if (div_a !== da || div_b !== db) begin
                opnd_bad <= opnd_bad + 1;
            end
            if (dcnt == LAT - 1)
                div_dout <= (db == '0) ? {da, {W{1'b1}}} : {da % db, da / db};
            else
                div_dout <= {$urandom, $urandom};
        end
    end

    function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sgn);
        logic signed [63:0] sa, sb, sq, sr;
        if (b == '0) return {a, {W{1'b1}}};
        if (sgn && SIGNED_EN) begin
            sa = $signed(a);
            sb = $signed(b);
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issue one nonzero-divisor divide and follow it to retirement; optionally pokes mthi
    // mid-flight, which must be ignored.
    task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input bit poke_mthi);
        logic [63:0] r;
        int cyc, ob0;
        bit ready_hi, rst_low, hold_bad;
        r   = ref_div(a, b, sgn);
        ob0 = opnd_bad;
        req_valid = 1'b1; req_a = a; req_b = b; req_signed = sgn;
        #1;
        check($sformatf("%s_ready", tag), 64'(req_ready), 64'd1);
        @(posedge clk);
        #1; req_valid = 1'b0; #1;
        cyc = 0; ready_hi = 0; rst_low = 0; hold_bad = 0;
        while (!done && cyc < 60) begin
            if (req_ready) ready_hi = 1;
            if (!div_rst) rst_low = 1;
            if (hi !== exp_hi || lo !== exp_lo) hold_bad = 1;
            mthi = poke_mthi && (cyc == 5);
            mt_data = 32'hA5A5_A5A5;
            step();
            cyc++;
        end
        mthi = 1'b0;
        check($sformatf("%s_latency", tag), 64'(cyc), 64'(LAT + 2));
        check($sformatf("%s_ready_low", tag), 64'(ready_hi), 64'd0);
        check($sformatf("%s_divrst_low", tag), 64'(rst_low), 64'd1);
        check($sformatf("%s_hilo_hold", tag), 64'(hold_bad), 64'd0);
        step();
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        check($sformatf("%s_hi", tag), 64'(hi), 64'(exp_hi));
        check($sformatf("%s_lo", tag), 64'(lo), 64'(exp_lo));
        check($sformatf("%s_done_once", tag), 64'(done), 64'd0);
        check($sformatf("%s_idle", tag), 64'({busy, req_ready}), 64'b01);
        check($sformatf("%s_opnd_stable", tag), 64'(opnd_bad - ob0), 64'd0);
    endtask

    // Watch for n cycles that no done appears and HI/LO stay put.
    task automatic quiet(input string tag, input int n);
        int pulses;
        bit hold_bad;
        pulses = 0; hold_bad = 0;
        for (int i = 0; i < n; i++) begin
            if (done) pulses++;
            if (hi !== exp_hi || lo !== exp_lo) hold_bad = 1;
            step();
        end
        check($sformatf("%s_no_done", tag), 64'(pulses), 64'd0);
        check($sformatf("%s_hilo", tag), 64'(hold_bad), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic rs;
        reset = 1'b1; req_valid = 1'b0; req_signed = 1'b0; cancel = 1'b0;
        mthi = 1'b0; mtlo = 1'b0; req_a = '0; req_b = '0; mt_data = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_outputs", 64'({req_ready, busy, done, div_rst}), 64'b0001);
        reset = 1'b0;
        #1;
        check("rst_hilo", 64'({hi, lo}), 64'd0);
        check("rst_div_ab", 64'({div_a, div_b}), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd1);

        do_div("d100_7", 32'd100, 32'd7, 1'b0, 1'b0);
        check("d100_7_const", 64'({hi, lo}), {32'd2, 32'd14});
        do_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        check("dmax_1_const", 64'({hi, lo}), {32'd0, 32'hFFFF_FFFF});
        do_div("b2b_9_2", 32'd9, 32'd2, 1'b0, 1'b0);
        check("b2b_9_2_const", 64'({hi, lo}), {32'd1, 32'd4});
        do_div("b2b_8_4", 32'd8, 32'd4, 1'b0, 1'b0);
        check("b2b_8_4_const", 64'({hi, lo}), {32'd0, 32'd2});

        // Divide by zero shortcut.
        req_valid = 1'b1; req_a = 32'd55; req_b = '0;
        #1;
        check("dz_done", 64'({done, div_rst}), 64'b11);
        @(posedge clk);
        #1; req_valid = 1'b0; #1;
        exp_hi = 32'd55; exp_lo = 32'hFFFF_FFFF;
        check("dz_hilo", 64'({hi, lo}), {exp_hi, exp_lo});
        check("dz_done_once", 64'({done, busy, div_rst}), 64'b001);

        // mtlo in the same cycle as a divide-by-zero: mt wins for LO only.
        req_valid = 1'b1; req_a = 32'd7; req_b = '0; mtlo = 1'b1; mt_data = 32'h1234_5678;
        step();
        req_valid = 1'b0; mtlo = 1'b0;
        exp_hi = 32'd7; exp_lo = 32'h1234_5678;
        check("dz_mt_hilo", 64'({hi, lo}), {exp_hi, exp_lo});

        // cancel in IDLE drops the transfer.
        req_valid = 1'b1; req_a = 32'd3; req_b = 32'd1; cancel = 1'b1;
        #1;
        check("idle_cancel_done", 64'(done), 64'd0);
        step();
        req_valid = 1'b0; cancel = 1'b0;
        check("idle_cancel_busy", 64'(busy), 64'd0);
        quiet("idle_cancel", 40);

        // cancel once the counter reaches 10.
        req_valid = 1'b1; req_a = 32'd1000; req_b = 32'd3;
        step();
        req_valid = 1'b0;
        repeat (11) step();
        cancel = 1'b1;
        #1;
        check("wait_cancel_out", 64'({done, div_rst}), 64'b01);
        step();
        cancel = 1'b0;
        check("wait_cancel_busy", 64'(busy), 64'd0);
        quiet("wait_cancel", 45);

        // reset once the counter reaches 20.
        req_valid = 1'b1; req_a = 32'd999; req_b = 32'd5;
        step();
        req_valid = 1'b0;
        repeat (21) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check("mid_reset_hilo", 64'({hi, lo}), 64'd0);
        check("mid_reset_ab", 64'({div_a, div_b}), 64'd0);
        check("mid_reset_busy", 64'(busy), 64'd0);
        quiet("mid_reset", 45);

        // mthi while busy is ignored; in IDLE it lands.
        do_div("mt_busy", 32'd50, 32'd6, 1'b0, 1'b1);
        mthi = 1'b1; mt_data = 32'hA5A5_A5A5;
        step();
        mthi = 1'b0;
        exp_hi = 32'hA5A5_A5A5;
        check("mthi_idle", 64'({hi, lo}), {exp_hi, exp_lo});
        mtlo = 1'b1; mt_data = 32'h0BAD_F00D;
        step();
        mtlo = 1'b0;
        exp_lo = 32'h0BAD_F00D;
        check("mtlo_idle", 64'({hi, lo}), {exp_hi, exp_lo});

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 100)) : $urandom;
            if (rb == '0) rb = 32'd1;
            rs = 1'($urandom_range(0, 1));
            do_div($sformatf("rnd%0d", i), ra, rb, rs, 1'b0);
        end

`ifdef SIGNED_DIV_EN
        do_div("s_m7_2", -32'sd7, 32'd2, 1'b1, 1'b0);
        check("s_m7_2_const", 64'({hi, lo}), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
`else
        do_div("u_m7_2", -32'sd7, 32'd2, 1'b1, 1'b0);
        check("u_m7_2_const", 64'({hi, lo}), {32'd1, 32'h7FFF_FFFC});
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
